// File: rtl/synth_pkg.sv
// Shared constants and types for the sine-table voice scheduler.
package synth_pkg;

  localparam int unsigned TABLE_LEN = 48000;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned SAMPLE_W  = 24;
  localparam int unsigned FREQ_MAX  = 24000;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sched_state_t;

endpackage

// File: rtl/phase_wrap_add.sv
// Phase step: clamps frequency to Nyquist and adds modulo the table length.
module phase_wrap_add
  import synth_pkg::*;
#(
  parameter int unsigned FREQ_W = 15
) (
  input  logic [ADDR_W-1:0] phase,
  input  logic [FREQ_W-1:0] freq,
  output logic [ADDR_W-1:0] next_phase
);

  logic [ADDR_W:0] f_clamped;
  logic [ADDR_W:0] sum;

  always_comb begin
    f_clamped = (32'(freq) > FREQ_MAX) ? (ADDR_W+1)'(FREQ_MAX) : (ADDR_W+1)'(freq);
    sum       = {1'b0, phase} + f_clamped;
    // Both operands are below TABLE_LEN, so one subtraction always wraps correctly.
    if (32'(sum) >= TABLE_LEN) next_phase = ADDR_W'(32'(sum) - TABLE_LEN);
    else                       next_phase = ADDR_W'(sum);
  end

endmodule

// File: rtl/sine_voice_sched.sv
// Shares one registered sine ROM among N_VOICES voices: one lookup per voice per
// sample tick, results summed and presented with a single-cycle valid strobe.
module sine_voice_sched
  import synth_pkg::*;
#(
  parameter int unsigned N_VOICES = 4,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned FREQ_W   = 15
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        sample_tick,
  input  logic [N_VOICES-1:0]                         voice_en,
  input  logic [N_VOICES*FREQ_W-1:0]                  voice_freq,
  output logic [ADDR_W-1:0]                           rom_addr,
  input  logic signed [SAMPLE_W-1:0]                  rom_data,
  output logic signed [SAMPLE_W+$clog2(N_VOICES)-1:0] mix_out,
  output logic                                        out_valid,
  output logic                                        busy,
  output logic                                        overrun
);

  localparam int unsigned MIX_W  = SAMPLE_W + $clog2(N_VOICES);
  localparam int unsigned SLOT_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int unsigned CNT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  sched_state_t            state_q;
  logic [SLOT_W-1:0]       slot_q;
  logic [CNT_W-1:0]        drain_q;
  logic [N_VOICES-1:0]     en_q;
  logic [FREQ_W-1:0]       freq_q  [N_VOICES];
  logic [ADDR_W-1:0]       phase_q [N_VOICES];
  logic [ROM_LAT-1:0]      tag_q, tag_d;
  logic signed [MIX_W-1:0] acc_q, acc_sum, addend;
  logic [ADDR_W-1:0]       next_phase;
  logic [SLOT_W-1:0]       slot_nxt;
  logic                    slot_last;

  phase_wrap_add #(
    .FREQ_W (FREQ_W)
  ) u_wrap (
    .phase      (phase_q[slot_q]),
    .freq       (freq_q[slot_q]),
    .next_phase (next_phase)
  );

  always_comb begin
    slot_nxt  = slot_q + 1'b1;
    slot_last = (slot_q == SLOT_W'(N_VOICES - 1));
    // Tag enters when a slot's address has been held for one cycle, so the oldest
    // tag lines up with that slot's rom_data ROM_LAT cycles later.
    tag_d     = tag_q << 1;
    tag_d[0]  = (state_q == ISSUE) && en_q[slot_q];
    addend    = tag_q[ROM_LAT-1] ? MIX_W'(rom_data) : '0;
    acc_sum   = acc_q + addend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      drain_q   <= '0;
      en_q      <= '0;
      tag_q     <= '0;
      acc_q     <= '0;
      rom_addr  <= '0;
      mix_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < N_VOICES; k++) begin
        freq_q[k]  <= '0;
        phase_q[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      tag_q     <= tag_d;
      acc_q     <= acc_sum;
      if (sample_tick && state_q != IDLE) overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            en_q <= voice_en;
            for (int k = 0; k < N_VOICES; k++) freq_q[k] <= voice_freq[k*FREQ_W +: FREQ_W];
            busy     <= 1'b1;
            rom_addr <= phase_q[0];
            slot_q   <= '0;
            acc_q    <= '0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          phase_q[slot_q] <= en_q[slot_q] ? next_phase : '0;
          if (slot_last) begin
            drain_q <= '0;
            state_q <= DRAIN;
          end else begin
            slot_q   <= slot_nxt;
            rom_addr <= phase_q[slot_nxt];
          end
        end
        DRAIN: begin
          if (drain_q == CNT_W'(ROM_LAT - 1)) begin
            mix_out   <= acc_sum;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_voice_sched.sv
// Randomised scoreboard bench for sine_voice_sched with a frame-level reference model.
module tb_sine_voice_sched;

  localparam int NV  = 4;
  localparam int LAT = 1;
  localparam int FW  = 15;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                sample_tick;
  logic [NV-1:0]       voice_en;
  logic [NV*FW-1:0]    voice_freq;
  logic [16:0]         rom_addr;
  logic signed [23:0]  rom_data;
  logic signed [25:0]  mix_out;
  logic                out_valid;
  logic                busy;
  logic                overrun;

  sine_voice_sched #(
    .N_VOICES (NV),
    .ROM_LAT  (LAT),
    .FREQ_W   (FW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .voice_freq  (voice_freq),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .mix_out     (mix_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // External ROM stand-in: registered read, returns its address or a constant.
  logic        rom_mode;
  logic [23:0] rom_const;
  always @(posedge clk) rom_data <= rom_mode ? rom_const : {7'b0, rom_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int mix; int due; } mix_exp_t;
  typedef struct { int a [NV]; } addr_exp_t;
  mix_exp_t  mix_q [$];
  addr_exp_t addr_q [$];

  // Reference model: frame-level phases and sums.
  int m_phase [NV];
  int m_last_start = -100;
  bit m_ovr = 0;

  function automatic int rom_val(input int addr);
    logic signed [23:0] c;
    c = rom_const;
    return rom_mode ? int'(c) : addr;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NV; k++) m_phase[k] = 0;
    m_last_start = -100;
    m_ovr = 0;
    mix_q.delete();
    addr_q.delete();
  endtask

  // Called on the negedge where sample_tick is driven; the DUT samples it on edge cyc+1.
  task automatic model_tick();
    int e;
    int sum;
    int f;
    addr_exp_t ae;
    mix_exp_t me;
    e = cyc + 1;
    if (e - m_last_start <= NV + LAT) begin
      m_ovr = 1;
      return;
    end
    m_last_start = e;
    sum = 0;
    for (int k = 0; k < NV; k++) begin
      ae.a[k] = m_phase[k];
      if (voice_en[k]) begin
        sum += rom_val(m_phase[k]);
        f = int'(voice_freq[k*FW +: FW]);
        if (f > 24000) f = 24000;
        m_phase[k] = (m_phase[k] + f) % 48000;
      end else begin
        m_phase[k] = 0;
      end
    end
    me.mix = sum;
    me.due = e + NV + LAT;
    mix_q.push_back(me);
    addr_q.push_back(ae);
  endtask

  // Monitor: compares slot addresses during busy and the mix on out_valid.
  int        bcnt = 0;
  addr_exp_t cur_addr;
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) begin
        if (bcnt == 0) begin
          if (addr_q.size() == 0) check("unexpected frame start", busy, 0);
          else cur_addr = addr_q.pop_front();
        end
        if (bcnt < NV) check($sformatf("slot%0d addr", bcnt), rom_addr, cur_addr.a[bcnt]);
        bcnt++;
      end else begin
        bcnt = 0;
      end
      if (out_valid) begin
        if (mix_q.size() == 0) begin
          check("unexpected out_valid", out_valid, 0);
        end else begin
          mix_exp_t e;
          e = mix_q.pop_front();
          check("mix_out", mix_out, e.mix);
          check("out_valid latency", cyc, e.due);
        end
      end
    end else begin
      bcnt = 0;
    end
  end

  task automatic set_voice(input int k, input bit en, input int f);
    voice_en[k] = en;
    voice_freq[k*FW +: FW] = FW'(f);
  endtask

  task automatic tick_frame(input int idle);
    @(negedge clk);
    sample_tick = 1'b1;
    model_tick();
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    sample_tick = 1'b0;
    voice_en    = '0;
    voice_freq  = '0;
    rom_mode    = 1'b0;
    rom_const   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset rom_addr", rom_addr, 0);
    check("reset mix_out", mix_out, 0);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun, 0);
    reset_n = 1'b1;

    // Wrap sequences: 1000 Hz, Nyquist, clamped, and frozen voices.
    set_voice(0, 1, 1000);
    set_voice(1, 1, 24000);
    set_voice(2, 1, 30000);
    set_voice(3, 1, 0);
    repeat (50) tick_frame(6);

    // Full-scale constants: sign extension with no overflow.
    for (int k = 0; k < NV; k++) set_voice(k, 1, 0);
    rom_mode  = 1'b1;
    rom_const = 24'h7FFFFF;
    tick_frame(6);
    rom_const = 24'h800000;
    tick_frame(6);
    check("max negative mix", mix_out, -33554432);
    rom_mode = 1'b0;
    check("overrun before drop", overrun, 0);

    // Second tick two cycles after the first is dropped; overrun sticks.
    for (int k = 0; k < NV; k++) set_voice(k, 1, 700 * (k + 1));
    @(negedge clk);
    sample_tick = 1'b1;
    model_tick();
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    model_tick();
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (6) @(negedge clk);
    check("overrun set", overrun, m_ovr);
    tick_frame(6);
    check("overrun sticky", overrun, 1);

    // Disabling voice0 mid-frame only affects the following frame.
    tick_frame(0);
    voice_en[0] = 1'b0;
    repeat (6) @(negedge clk);
    tick_frame(6);
    voice_en[0] = 1'b1;
    tick_frame(6);

    // Asynchronous reset during slot 2.
    @(negedge clk);
    sample_tick = 1'b1;
    model_tick();
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid reset busy", busy, 0);
    check("mid reset out_valid", out_valid, 0);
    check("mid reset mix_out", mix_out, 0);
    check("mid reset rom_addr", rom_addr, 0);
    check("mid reset overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no partial out_valid", out_valid, 0);
    tick_frame(6);
    tick_frame(6);

    // Random traffic: inputs wander every cycle, ticks at random spacing.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NV; k++) begin
          int sel;
          sel = int'($urandom_range(0, 5));
          set_voice(k, ($urandom_range(0, 3) != 0),
                    (sel == 0) ? 0 : (sel == 1) ? 24000 : int'($urandom_range(0, 32767)));
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        sample_tick = 1'b1;
        model_tick();
      end else begin
        sample_tick = 1'b0;
      end
    end
    @(negedge clk);
    sample_tick = 1'b0;

    // Bounded drain of outstanding frames.
    for (int t = 0; t < 50 && mix_q.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("pending frames", mix_q.size(), 0);
    check("final overrun", overrun, m_ovr);
    check("idle busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
